// File: rtl/ad5302_pkg.sv
// Shared constants, FSM state type and command-word builder for the AD5302 sequencer.
package ad5302_pkg;

  localparam int CH_BIT   = 15;
  localparam int BUF_BIT  = 14;
  localparam int PD_LSB   = 12;
  localparam int CODE_LSB = 4;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GUARD
  } state_t;

  // {ch, buf, pd[1:0], code[7:0], 4'h0}
  function automatic logic [15:0] build_word(input logic ch, input logic buf_en,
                                             input logic [1:0] pd, input logic [7:0] code);
    logic [15:0] w;
    w                 = '0;
    w[CH_BIT]         = ch;
    w[BUF_BIT]        = buf_en;
    w[PD_LSB +: 2]    = pd;
    w[CODE_LSB +: 8]  = code;
    return w;
  endfunction

endpackage

// File: rtl/ad5302_rr_arb.sv
// Two-client round-robin arbiter: one-hot grant, pointer flips away from the served client.
module ad5302_rr_arb
  import ad5302_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  input  logic       served,
  output logic [1:0] gnt,
  output logic       upd
);

  logic ptr;

  always_ff @(posedge clk) begin
    if (!rst_n)   ptr <= 1'b0;
    else if (adv) ptr <= ~served;
  end

  // Pointer only matters on contention; a lone requester always wins.
  always_comb begin
    gnt = req;
    if (&req) gnt = ptr ? 2'b10 : 2'b01;
  end

  assign upd = |req;

endmodule

// File: rtl/ad5302_ctrl.sv
// AD5302 command sequencer: per-channel pending setpoints, init writes after reset,
// round-robin word issue over a stream master port with a post-handshake guard gap.
module ad5302_ctrl
  import ad5302_pkg::*;
#(
  parameter logic [7:0] INIT_A    = 8'h00,
  parameter logic [7:0] INIT_B    = 8'h00,
  parameter logic       BUF_EN    = 1'b0,
  parameter int         GUARD_CYC = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        a_req,
  input  logic [7:0]  a_data,
  input  logic        b_req,
  input  logic [7:0]  b_data,
  input  logic [1:0]  pd_mode,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [15:0] m_axis_tdata,
  output logic        a_done,
  output logic        b_done,
  output logic        init_done,
  output logic        busy
);

  state_t     state;
  logic       pend_a, pend_b;
  logic [7:0] val_a, val_b;
  logic       sel_b;
  logic       seen_a, seen_b;
  logic [3:0] guard_cnt;
  logic [1:0] gnt;
  logic       pick;
  logic       hs;

  assign hs = (state == SEND) && m_axis_tready;

  // Requests are only presented in IDLE so the arbiter strobe doubles as "select now".
  ad5302_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({pend_b, pend_a} & {2{state == IDLE}}),
    .adv    (hs),
    .served (sel_b),
    .gnt    (gnt),
    .upd    (pick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      pend_a        <= 1'b1;
      pend_b        <= 1'b1;
      val_a         <= INIT_A;
      val_b         <= INIT_B;
      sel_b         <= 1'b0;
      seen_a        <= 1'b0;
      seen_b        <= 1'b0;
      guard_cnt     <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      a_done        <= 1'b0;
      b_done        <= 1'b0;
      init_done     <= 1'b0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      case (state)
        IDLE: if (pick) begin
          sel_b         <= gnt[1];
          m_axis_tdata  <= build_word(gnt[1], BUF_EN, pd_mode, gnt[1] ? val_b : val_a);
          m_axis_tvalid <= 1'b1;
          state         <= SEND;
        end
        SEND: if (m_axis_tready) begin
          m_axis_tvalid <= 1'b0;
          a_done        <= ~sel_b;
          b_done        <= sel_b;
          seen_a        <= seen_a | ~sel_b;
          seen_b        <= seen_b | sel_b;
          init_done     <= init_done | ((seen_a | ~sel_b) & (seen_b | sel_b));
          if (GUARD_CYC == 0) begin
            state <= IDLE;
          end else begin
            guard_cnt <= 4'(GUARD_CYC);
            state     <= GUARD;
          end
        end
        GUARD: begin
          guard_cnt <= guard_cnt - 4'd1;
          if (guard_cnt <= 4'd1) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A fresh request beats the clear from selection in the same cycle.
      if (a_req) begin
        pend_a <= 1'b1;
        val_a  <= a_data;
      end else if (pick && gnt[0]) begin
        pend_a <= 1'b0;
      end
      if (b_req) begin
        pend_b <= 1'b1;
        val_b  <= b_data;
      end else if (pick && gnt[1]) begin
        pend_b <= 1'b0;
      end
    end
  end

  assign busy = (state != IDLE) | pend_a | pend_b;

endmodule

// File: tb/tb_ad5302_ctrl.sv
// Directed and randomized check of ad5302_ctrl against a transaction-level reference model.
module tb_ad5302_ctrl;

  localparam int   G   = 4;
  localparam logic BUF = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [7:0]  a_data = '0, b_data = '0;
  logic [1:0]  pd_mode = '0;
  logic        tready = 1'b0;
  logic        tvalid, a_done, b_done, init_done, busy;
  logic [15:0] tdata;

  always #4 clk = ~clk;

  ad5302_ctrl #(.INIT_A(8'h00), .INIT_B(8'h00), .BUF_EN(BUF), .GUARD_CYC(G)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_data(a_data), .b_req(b_req), .b_data(b_data),
    .pd_mode(pd_mode),
    .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata),
    .a_done(a_done), .b_done(b_done), .init_done(init_done), .busy(busy)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  // Reference model: latest value and pending flag per channel, who is next on contention,
  // which channels have been accepted since reset, and the edge of the last handshake.
  bit          mpend[2];
  logic [7:0]  mval[2];
  bit          mnext;
  bit          mseen[2];
  bit          cur_ch;
  int          ecnt = 0;
  int          last_hs;
  logic [15:0] acc_q[$];
  int          hs_q[$];

  function automatic logic [15:0] word(input bit ch, input logic [1:0] pd, input logic [7:0] code);
    return {ch, BUF, pd, code, 4'h0};
  endfunction

  task automatic model_reset();
    mpend = '{1'b1, 1'b1};
    mval  = '{8'h00, 8'h00};
    mnext = 1'b0;
    mseen = '{1'b0, 1'b0};
    cur_ch = 1'b0;
    last_hs = -1000;
  endtask

  // One clock: capture what the DUT sees, let the edge happen, then check against the model.
  task automatic step();
    logic pv, prdy, prst, ar, br, hs, exp_v, selv;
    logic [15:0] pd16;
    logic [7:0] ad, bd;
    logic [1:0] pd;
    bit ch;
    pv = tvalid; pd16 = tdata; prdy = tready; prst = rst_n;
    ar = a_req; br = b_req; ad = a_data; bd = b_data; pd = pd_mode;
    @(posedge clk);
    #1;
    ecnt++;
    if (!prst) begin
      chk("rst_tvalid", tvalid, 0);
      chk("rst_tdata", tdata, 16'h0000);
      chk("rst_done", {a_done, b_done}, 2'b00);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 1);
      model_reset();
    end else begin
      hs = pv && prdy;
      // A new word may be offered only when nothing is in flight and the guard gap has elapsed.
      selv = !pv && (ecnt - last_hs >= G + 1) && (mpend[0] || mpend[1]);
      ch = (mpend[0] && mpend[1]) ? mnext : mpend[1];
      exp_v = hs ? 1'b0 : (pv ? 1'b1 : selv);
      chk("tvalid", tvalid, exp_v);
      if (pv && !hs) chk("tdata_hold", tdata, pd16);
      if (selv) begin
        chk("word", tdata, word(ch, pd, mval[ch]));
        mpend[ch] = 1'b0;
        cur_ch = ch;
      end
      chk("a_done", a_done, hs && !cur_ch);
      chk("b_done", b_done, hs && cur_ch);
      if (hs) begin
        acc_q.push_back(pd16);
        hs_q.push_back(ecnt);
        mnext = !cur_ch;
        mseen[cur_ch] = 1'b1;
        last_hs = ecnt;
      end
      if (ar) begin mpend[0] = 1'b1; mval[0] = ad; end
      if (br) begin mpend[1] = 1'b1; mval[1] = bd; end
      chk("init_done", init_done, mseen[0] && mseen[1]);
      chk("busy", busy, exp_v || (ecnt - last_hs < G) || mpend[0] || mpend[1]);
    end
  endtask

  task automatic drive(input logic ar, input logic [7:0] ad, input logic br,
                       input logic [7:0] bd, input logic rdy);
    a_req = ar; a_data = ad; b_req = br; b_data = bd; tready = rdy;
    step();
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task automatic run(input int n, input logic rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, 8'h00, rdy);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 60 && !tvalid; i++) run(1, tready);
    chk(tag, tvalid, 1);
  endtask

  int n0;

  initial begin
    model_reset();
    // Init sequence: A then B with the INIT codes
    rst_n = 1'b0;
    run(3, 1'b1);
    rst_n = 1'b1;
    n0 = acc_q.size();
    run(20, 1'b1);
    chk("init_cnt", acc_q.size() - n0, 2);
    chk("init_word_a", acc_q[n0], 16'h0000);
    chk("init_word_b", acc_q[n0+1], 16'h8000);
    chk("init_done_set", init_done, 1);
    chk("busy_after_init", busy, 0);

    // Simultaneous requests with pointer on A, handshakes G+2 apart
    n0 = acc_q.size();
    drive(1'b1, 8'h11, 1'b1, 8'h22, 1'b1);
    run(20, 1'b1);
    chk("both_cnt", acc_q.size() - n0, 2);
    chk("both_first", acc_q[n0], 16'h0110);
    chk("both_second", acc_q[n0+1], 16'h8220);
    chk("both_gap", hs_q[hs_q.size()-1] - hs_q[hs_q.size()-2], G + 2);

    // Request-to-offer latency and stall stability
    drive(1'b1, 8'hA5, 1'b0, 8'h00, 1'b0);
    run(1, 1'b0);
    chk("lat_tvalid", tvalid, 1);
    chk("lat_tdata", tdata, 16'h0A50);
    run(10, 1'b0);
    chk("stall_tdata", tdata, 16'h0A50);
    run(1, 1'b1);
    chk("a5_done", a_done, 1);
    run(1, 1'b1);
    chk("a5_done_once", a_done, 0);
    run(10, 1'b1);

    // Coalesced A requests behind a stalled B word
    n0 = acc_q.size();
    drive(1'b0, 8'h00, 1'b1, 8'h55, 1'b0);
    wait_valid("b55_offer");
    drive(1'b1, 8'h01, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h02, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
    run(20, 1'b1);
    chk("coal_cnt", acc_q.size() - n0, 2);
    chk("coal_b", acc_q[n0], 16'h8550);
    chk("coal_a", acc_q[n0+1], 16'h0030);

    // Request landing on its own channel's handshake re-arms it
    n0 = acc_q.size();
    drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b0);
    wait_valid("a33_offer");
    drive(1'b1, 8'h44, 1'b0, 8'h00, 1'b1);
    run(20, 1'b1);
    chk("rearm_cnt", acc_q.size() - n0, 2);
    chk("rearm_first", acc_q[n0], 16'h0330);
    chk("rearm_second", acc_q[n0+1], 16'h0440);

    // Reset in the middle of SEND abandons the word and restarts init
    drive(1'b0, 8'h00, 1'b1, 8'h77, 1'b0);
    wait_valid("b77_offer");
    rst_n = 1'b0;
    run(2, 1'b1);
    rst_n = 1'b1;
    n0 = acc_q.size();
    run(20, 1'b1);
    chk("reinit_cnt", acc_q.size() - n0, 2);
    chk("reinit_a", acc_q[n0], 16'h0000);
    chk("reinit_b", acc_q[n0+1], 16'h8000);

    // Randomized traffic, stalls, pd_mode changes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      pd_mode = 2'($urandom_range(0, 3));
      rst_n = ($urandom_range(0, 599) != 0);
      drive($urandom_range(0, 6) == 0, 8'($urandom), $urandom_range(0, 6) == 0, 8'($urandom),
            $urandom_range(0, 3) != 0);
    end
    rst_n = 1'b1;
    run(40, 1'b1);
    chk("drain_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ad5302_ctrl.md
# ad5302_ctrl

Command sequencer and two-client arbiter in front of the AD5302 SPI driver in the scanner DAC path. Keeps one pending setpoint per DAC channel (A, B) and builds the 16-bit AD5302 command words. Issues the words one at a time over an AXI-Stream-style master port into the driver's 16-bit slave port. After reset it writes programmable initial codes to both channels before it serves any client.

## Interface
Parameters:
- INIT_A, 8'h00, code written to channel A after reset.
- INIT_B, 8'h00, code written to channel B after reset.
- BUF_EN, 1'b0, value of the BUF bit in every command word.
- GUARD_CYC, 4, idle clocks after each handshake before the next word may be offered. Range 0..15.

Ports:
- clk, in, 1, system clock (125 MHz).
- rst_n, in, 1, synchronous reset, active-low.
- a_req, in, 1, one-cycle strobe that loads a_data as the channel A setpoint.
- a_data, in, 8, channel A code.
- b_req, in, 1, one-cycle strobe that loads b_data as the channel B setpoint.
- b_data, in, 8, channel B code.
- pd_mode, in, 2, PD1:PD0 field. Sampled when a word is loaded.
- m_axis_tvalid, out, 1, a command word is offered.
- m_axis_tready, in, 1, driver ready; connects to the driver's s_axis_tready.
- m_axis_tdata, out, 16, command word.
- a_done, out, 1, one-cycle pulse after a channel A word is accepted.
- b_done, out, 1, one-cycle pulse after a channel B word is accepted.
- init_done, out, 1, high once both initial words are accepted; sticky until reset.
- busy, out, 1, high in every state other than IDLE, or while any setpoint is pending.

## Operation
- Command word layout:
  - [15] channel select, 0 = A, 1 = B.
  - [14] BUF_EN.
  - [13:12] pd_mode.
  - [11:4] code.
  - [3:0] 0.
- Per-channel state: pend_x flag and val_x[7:0].
- Client request:
  - x_req sets pend_x and overwrites val_x.
  - Requests coalesce: only the latest value is sent.
  - If x_req and a clear of pend_x by selection fall in the same cycle, the set wins and val_x takes the new data.
- Reset loads val_a = INIT_A, val_b = INIT_B, pend_a = pend_b = 1, round-robin pointer = A. The init order is therefore A then B.
- Client requests that arrive during init are accepted and coalesce into the pending values. As a result, the first word per channel may carry a client code instead of the INIT code.
- init_done rises in the cycle after the second distinct channel's handshake following reset.
- FSM states and transitions:
  - IDLE: if any pend_x is set, pick a channel, register tdata from {sel, BUF_EN, pd_mode, val_sel, 4'h0}, clear pend_sel, go to SEND.
  - SEND: tvalid = 1. tdata is held stable until the handshake (tvalid and tready). On the handshake, drop tvalid, pulse the done output for the selected channel, flip the pointer away from the served channel, load the guard counter, go to GUARD. If GUARD_CYC = 0, go to IDLE instead.
  - GUARD: decrement the counter; at 1, go to IDLE.
- Arbitration:
  - If only one channel is pending, serve it.
  - If both are pending, serve the channel the pointer names.
  - This gives strict alternation under sustained load.
- pd_mode and BUF_EN are not re-sent on their own. A pd_mode change takes effect with the next word for each channel.

## Timing
- Reset values of all outputs: m_axis_tvalid = 0, m_axis_tdata = 16'h0000, a_done = b_done = 0, init_done = 0, busy = 1. busy is 1 because init words are pending.
- Latency from request to offer: x_req at cycle n, pend_x visible at n+1, selection in IDLE at n+1, tvalid high at n+2 (best case, FSM in IDLE).
- Done pulse: handshake at cycle h, x_done = 1 at h+1 for exactly one cycle.
- Next offer after a handshake at h: tvalid can rise no earlier than h+GUARD_CYC+2.
- tvalid is never withdrawn before the handshake. tdata does not change while tvalid = 1.
- A request arriving while its own channel is in SEND re-arms pend_x. That channel is re-sent after the guard, unless the other channel is pending, in which case alternation holds.
- rst_n low takes effect at the next clock edge, from any state. It drops tvalid, abandons the word in flight, and restarts init.

## Structure
- Package ad5302_pkg holds:
  - field position constants (CH_BIT = 15, BUF_BIT = 14, PD_LSB = 12, CODE_LSB = 4).
  - the FSM state enum (IDLE, SEND, GUARD).
  - a function that builds the word from (ch, buf, pd, code).
- One sub-module: ad5302_rr_arb. It takes 2 request inputs, holds a pointer register, and outputs a one-hot grant and an update strobe.
- At top level, ad5302_ctrl drives the existing driver instance; ldac_n stays tied low.

## Test plan
- Reset release with tready = 1 and GUARD_CYC = 4 → words 16'h0000 (A) then 16'h8000 (B), init_done high after the second handshake, busy low afterward.
- After init, a_req with a_data = 8'hA5 and pd_mode = 0 → tdata = 16'h0A50 two cycles later. Hold tready low for 10 cycles → tvalid and tdata stay stable. On acceptance → a_done pulses once.
- a_req with 8'h11 and b_req with 8'h22 in the same cycle, pointer = A → 16'h0110, then 16'h8220 with GUARD_CYC+2 cycles between handshakes.
- Three a_req (8'h01, 8'h02, 8'h03) while a channel B word is in SEND → exactly one A word follows it, 16'h0030.
- a_req with 8'h44 in the cycle of an A handshake (previous code 8'h33) → 16'h0330 is accepted, then 16'h0440 is sent.
- Reset asserted mid-SEND → tvalid = 0 at the next edge, init restarts, no done pulse for the aborted word.
